// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if
//   One cache-style physical-memory port: 128-bit line, 16-bit line address.
//   Used three times around the arbiter: the I-cache port, the D-cache port
//   and the shared memory port.
//   master : drives read, write, address, wdata; receives rdata, resp
//   slave  : receives read, write, address, wdata; drives rdata, resp
interface cache_arbiter_if;
    logic         read;
    logic         write;
    logic [15:0]  address;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         resp;

    modport master (output read, write, address, wdata, input rdata, resp);
    modport slave  (input read, write, address, wdata, output rdata, resp);
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares the single physical-memory port between the I-cache and the
//   D-cache. One requester is granted at a time, ties are broken round-robin,
//   the winner's request is registered onto the memory port and the memory
//   response is routed back to the granted cache only.
// Ports
//   clk    : system clock
//   reset  : asynchronous, active-high
//   i_pmem : I-cache side (slave)
//   d_pmem : D-cache side (slave)
//   mem    : physical-memory side (master), strobes/address/wdata registered
module cache_arbiter (
    input  logic                   clk,
    input  logic                   reset,
    cache_arbiter_if.slave         i_pmem,
    cache_arbiter_if.slave         d_pmem,
    cache_arbiter_if.master        mem
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    typedef struct packed {
        logic         read;
        logic         write;
        logic [15:0]  address;
        logic [127:0] wdata;
    } pmem_req_t;

    state_t    state, state_next;
    logic      last_grant_d;     // 1: D was granted most recently
    logic      grant_i, grant_d;
    logic      i_req, d_req;
    pmem_req_t i_req_s, d_req_s, port_q;

    assign i_req   = i_pmem.read | i_pmem.write;
    assign d_req   = d_pmem.read | d_pmem.write;
    assign i_req_s = '{i_pmem.read, i_pmem.write, i_pmem.address, i_pmem.wdata};
    assign d_req_s = '{d_pmem.read, d_pmem.write, d_pmem.address, d_pmem.wdata};

    // Next state and grant decode. On a tie the requester that was not
    // granted last wins; last_grant resets to D so I wins the first tie.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_req && (!d_req || last_grant_d)) begin
                    grant_i    = 1'b1;
                    state_next = SERVE_I;
                end else if (d_req) begin
                    grant_d    = 1'b1;
                    state_next = SERVE_D;
                end
            end
            // The grant is held until memory answers, even if the requester
            // drops its request early.
            SERVE_I: if (mem.resp) state_next = IDLE;
            SERVE_D: if (mem.resp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
        end else begin
            state <= state_next;
            if (grant_i) last_grant_d <= 1'b0;
            if (grant_d) last_grant_d <= 1'b1;
        end
    end

    // Memory-port registers. Strobes clear on the response edge; address and
    // wdata stay put until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_q <= '0;
        end else if (grant_i) begin
            port_q <= i_req_s;
        end else if (grant_d) begin
            port_q <= d_req_s;
        end else if (state != IDLE && mem.resp) begin
            port_q.read  <= 1'b0;
            port_q.write <= 1'b0;
        end
    end

    assign mem.read    = port_q.read;
    assign mem.write   = port_q.write;
    assign mem.address = port_q.address;
    assign mem.wdata   = port_q.wdata;

    // Response goes only to the granted cache; a response in IDLE is a
    // stray and is dropped. Read data is broadcast, resp qualifies it.
    assign i_pmem.resp  = (state == SERVE_I) & mem.resp;
    assign d_pmem.resp  = (state == SERVE_D) & mem.resp;
    assign i_pmem.rdata = mem.rdata;
    assign d_pmem.rdata = mem.rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
//   Directed bench for cache_arbiter. Inputs change 1 time unit after the
//   rising edge; outputs are checked 1 time unit later, so registered
//   outputs show the value from the last edge and combinational responses
//   reflect the inputs of the current cycle.
module tb_cache_arbiter;

    logic clk;
    logic reset;

    cache_arbiter_if i_if ();
    cache_arbiter_if d_if ();
    cache_arbiter_if m_if ();

    cache_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .i_pmem (i_if),
        .d_pmem (d_if),
        .mem    (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [127:0] RD_A5 = {16{8'hA5}};
    localparam logic [127:0] WB_DB = {4{32'hDEAD_BEEF}};

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check the memory strobes/address in one call.
    task automatic chk_port(input string tag, input logic rd, input logic wr, input logic [15:0] addr);
        chk({tag, ".read"}, 128'(m_if.read), 128'(rd));
        chk({tag, ".write"}, 128'(m_if.write), 128'(wr));
        chk({tag, ".addr"}, 128'(m_if.address), 128'(addr));
    endtask

    task automatic chk_resp(input string tag, input logic ir, input logic dr);
        chk({tag, ".i_resp"}, 128'(i_if.resp), 128'(ir));
        chk({tag, ".d_resp"}, 128'(d_if.resp), 128'(dr));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    logic [15:0] ia, da, exp_addr;

    initial begin
        reset = 1'b1;
        i_if.read = 0; i_if.write = 0; i_if.address = '0; i_if.wdata = '0;
        d_if.read = 0; d_if.write = 0; d_if.address = '0; d_if.wdata = '0;
        m_if.rdata = '0; m_if.resp = 0;
        cyc(); cyc();

        // ---- reset state
        #1;
        chk_port("rst", 0, 0, 16'h0000);
        chk("rst.wdata", m_if.wdata, '0);
        chk_resp("rst", 0, 0);
        reset = 1'b0;
        cyc();
        chk_port("rel", 0, 0, 16'h0000);

        // ---- single I read, resp at n+4
        i_if.read = 1; i_if.address = 16'h1230;           // cycle n
        #1 chk_port("ird.n", 0, 0, 16'h0000);
        cyc();                                            // n+1
        chk_port("ird.n1", 1, 0, 16'h1230);
        chk_resp("ird.n1", 0, 0);
        cyc(); cyc();                                     // n+3
        chk_port("ird.n3", 1, 0, 16'h1230);
        cyc();                                            // n+4
        m_if.rdata = RD_A5; m_if.resp = 1;
        #1;
        chk_resp("ird.n4", 1, 0);
        chk("ird.rdata", i_if.rdata, RD_A5);
        cyc();                                            // n+5
        m_if.resp = 0; i_if.read = 0;
        #1;
        chk_port("ird.n5", 0, 0, 16'h1230);
        chk_resp("ird.n5", 0, 0);

        // ---- D writeback, with address change mid-transfer
        d_if.write = 1; d_if.address = 16'h4440; d_if.wdata = WB_DB;
        cyc();
        chk_port("dwb.n1", 0, 1, 16'h4440);
        chk("dwb.wdata1", m_if.wdata, WB_DB);
        d_if.address = 16'hFFFF;
        d_if.wdata = '0;
        cyc();
        chk_port("dwb.n2", 0, 1, 16'h4440);
        chk("dwb.wdata2", m_if.wdata, WB_DB);
        cyc();
        m_if.resp = 1;
        #1;
        chk_resp("dwb.resp", 0, 1);
        chk("dwb.wdata3", m_if.wdata, WB_DB);
        cyc();
        m_if.resp = 0; d_if.write = 0;
        #1 chk_port("dwb.done", 0, 0, 16'h4440);

        // ---- tie after reset: I first, then D two cycles after I's resp
        pulse_reset();
        i_if.read = 1; i_if.address = 16'h0010;
        d_if.read = 1; d_if.address = 16'h8020;
        cyc();
        chk_port("tie.g1", 1, 0, 16'h0010);
        cyc();
        m_if.resp = 1;
        #1 chk_resp("tie.r1", 1, 0);
        cyc();                                            // m+1: I re-requests
        m_if.resp = 0; i_if.address = 16'h0030;
        #1;
        chk_port("tie.gap", 0, 0, 16'h0010);
        chk_resp("tie.gap", 0, 0);
        cyc();                                            // m+2: repeat tie goes to D
        chk_port("tie.g2", 1, 0, 16'h8020);
        cyc();
        m_if.resp = 1;
        #1 chk_resp("tie.r2", 0, 1);
        cyc();
        m_if.resp = 0; d_if.read = 0;
        cyc();
        chk_port("tie.g3", 1, 0, 16'h0030);
        cyc();
        m_if.resp = 1;
        #1 chk_resp("tie.r3", 1, 0);
        cyc();
        m_if.resp = 0; i_if.read = 0;

        // ---- continuous contention: I, D, I, D, I, D
        pulse_reset();
        ia = 16'h1000; da = 16'h2000;
        i_if.read = 1; i_if.address = ia;
        d_if.read = 1; d_if.address = da;
        for (int k = 0; k < 6; k++) begin
            cyc();
            exp_addr = (k % 2 == 0) ? ia : da;
            chk_port($sformatf("rr%0d.g", k), 1, 0, exp_addr);
            cyc();
            m_if.resp = 1;
            #1 chk_resp($sformatf("rr%0d.r", k), (k % 2 == 0), (k % 2 == 1));
            cyc();
            m_if.resp = 0;
            if (k % 2 == 0) begin ia = ia + 16'h1; i_if.address = ia; end
            else            begin da = da + 16'h1; d_if.address = da; end
            #1 chk($sformatf("rr%0d.gap", k), 128'(m_if.read), 128'(0));
        end
        i_if.read = 0; d_if.read = 0;
        cyc();

        // ---- reset mid-transfer, stray resp, next tie to I
        d_if.read = 1; d_if.address = 16'h5550;
        cyc();
        chk_port("mid.g", 1, 0, 16'h5550);
        cyc();
        reset = 1'b1;
        #1;
        chk_port("mid.rst", 0, 0, 16'h0000);
        chk("mid.wdata", m_if.wdata, '0);
        chk_resp("mid.rst", 0, 0);
        d_if.read = 0;
        cyc();
        reset = 1'b0;
        m_if.resp = 1;                                    // late memory response
        #1 chk_resp("stray", 0, 0);
        cyc();
        m_if.resp = 0;
        #1 chk_port("stray.port", 0, 0, 16'h0000);
        i_if.read = 1; i_if.address = 16'h0AA0;
        d_if.read = 1; d_if.address = 16'h0BB0;
        cyc();
        chk_port("mid.tie", 1, 0, 16'h0AA0);
        cyc();
        m_if.resp = 1;
        #1 chk_resp("mid.tie.r", 1, 0);
        cyc();
        m_if.resp = 0; i_if.read = 0; d_if.read = 0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
